// File: rtl/iso_link_pkg.sv
// Shared types and default geometry for the isolator-board serial control link.
package iso_link_pkg;

  localparam int unsigned NumBitsDef   = 8;
  localparam int unsigned ClkDivDef    = 4;
  localparam int unsigned GapCyclesDef = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSclkHi,
    StSclkLo,
    StLatch,
    StGap
  } state_e;

endpackage

// File: rtl/iso_link_if.sv
// Host-side and lane-side signal bundle of the isolator link master.
interface iso_link_if
  import iso_link_pkg::*;
#(
  parameter int unsigned NUM_BITS = NumBitsDef
) ();

  logic                enable;
  logic [NUM_BITS-1:0] cs_n_par;
  logic [NUM_BITS-1:0] hwcon_par;
  logic [NUM_BITS-1:0] dirchan_par;
  logic [NUM_BITS-1:0] hwflag_par;
  logic                frame_done;
  logic                status_change;
  logic                busy;
  logic                sclk;
  logic                srclk;
  logic                cs_n;
  logic                hwcon;
  logic                dirchan;
  logic                hwflag;

  modport master (
    input  enable, cs_n_par, hwcon_par, dirchan, hwflag,
    output dirchan_par, hwflag_par, frame_done, status_change, busy,
    output sclk, srclk, cs_n, hwcon
  );

  modport slave (
    output enable, cs_n_par, hwcon_par, dirchan, hwflag,
    input  dirchan_par, hwflag_par, frame_done, status_change, busy,
    input  sclk, srclk, cs_n, hwcon
  );

endinterface

// File: rtl/iso_link_shreg.sv
// One lane pair: MSB-first parallel-load tx shifter and shift-left rx shifter.
module iso_link_shreg #(
  parameter int unsigned Width = 8,
  parameter logic        TxRst = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             sample_i,
  input  logic             rx_i,
  output logic             tx_o,
  output logic [Width-1:0] rx_data_o
);

  logic [Width-1:0] tx_q;
  logic [Width-1:0] rx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_q <= {Width{TxRst}};
      rx_q <= '0;
    end else begin
      if (load_i) begin
        tx_q <= load_data_i;
      end else if (shift_i) begin
        tx_q <= {tx_q[Width-2:0], 1'b0};
      end
      if (sample_i) begin
        rx_q <= {rx_q[Width-2:0], rx_i};
      end
    end
  end

  assign tx_o      = tx_q[Width-1];
  assign rx_data_o = rx_q;

endmodule

// File: rtl/iso_link_master.sv
// Isolator serial link master: frame FSM, sclk/srclk generation, status publish.
// Define ISO_LINK_STATUS_FILTER_EN to publish rx status only after two equal frames.
module iso_link_master
  import iso_link_pkg::*;
#(
  parameter int unsigned NUM_BITS   = NumBitsDef,
  parameter int unsigned CLK_DIV    = ClkDivDef,
  parameter int unsigned GAP_CYCLES = GapCyclesDef
) (
  input logic        clk,
  input logic        reset_n,
  iso_link_if.master bus
);

  localparam int unsigned PhMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam int unsigned BitW  = $clog2(NUM_BITS + 1);

  state_e              state_q;
  logic [PhW-1:0]      phase_q;
  logic [BitW-1:0]     bit_q;
  logic                sclk_q, srclk_q, busy_q, frame_done_q, status_change_q;
  logic [NUM_BITS-1:0] dirchan_par_q, hwflag_par_q;
  logic [NUM_BITS-1:0] dir_rx, hw_rx;
  logic                ph_last, load_en, sample_en, shift_en, latch_en, publish_en;

  always_comb begin
    ph_last = 1'b0;
    unique case (state_q)
      StLoad:                     ph_last = 1'b1;
      StSclkHi, StSclkLo, StLatch: ph_last = (phase_q == PhW'(CLK_DIV - 1));
      StGap:                      ph_last = (phase_q == PhW'(GAP_CYCLES - 1));
      default:                    ph_last = 1'b0;
    endcase
    load_en   = bus.enable && ((state_q == StIdle) || ((state_q == StGap) && ph_last));
    sample_en = (state_q == StSclkHi) && ph_last;
    // Last bit stays on the lane through its low phase.
    shift_en  = sample_en && (bit_q != '0);
    latch_en  = (state_q == StSclkLo) && ph_last && (bit_q == '0);
  end

`ifdef ISO_LINK_STATUS_FILTER_EN
  logic [2*NUM_BITS-1:0] cand_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= '0;
    end else if (latch_en) begin
      cand_q <= {dir_rx, hw_rx};
    end
  end

  assign publish_en = ({dir_rx, hw_rx} == cand_q);
`else
  assign publish_en = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      phase_q         <= '0;
      bit_q           <= '0;
      sclk_q          <= 1'b0;
      srclk_q         <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      status_change_q <= 1'b0;
      dirchan_par_q   <= '0;
      hwflag_par_q    <= '0;
    end else begin
      frame_done_q    <= 1'b0;
      status_change_q <= 1'b0;
      if (ph_last || (state_q == StIdle)) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (load_en) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
            bit_q   <= BitW'(NUM_BITS - 1);
          end
        end
        StLoad: begin
          state_q <= StSclkHi;
          sclk_q  <= 1'b1;
        end
        StSclkHi: begin
          if (ph_last) begin
            state_q <= StSclkLo;
            sclk_q  <= 1'b0;
          end
        end
        StSclkLo: begin
          if (latch_en) begin
            state_q      <= StLatch;
            srclk_q      <= 1'b1;
            frame_done_q <= 1'b1;
            if (publish_en) begin
              dirchan_par_q   <= dir_rx;
              hwflag_par_q    <= hw_rx;
              status_change_q <= ({dir_rx, hw_rx} != {dirchan_par_q, hwflag_par_q});
            end
          end else if (ph_last) begin
            state_q <= StSclkHi;
            sclk_q  <= 1'b1;
            bit_q   <= bit_q - 1'b1;
          end
        end
        StLatch: begin
          if (ph_last) begin
            state_q <= StGap;
            srclk_q <= 1'b0;
          end
        end
        StGap: begin
          if (load_en) begin
            state_q <= StLoad;
            bit_q   <= BitW'(NUM_BITS - 1);
          end else if (ph_last) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  iso_link_shreg #(
    .Width (NUM_BITS),
    .TxRst (1'b1)
  ) u_cs_lane (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .load_i      (load_en),
    .load_data_i (bus.cs_n_par),
    .shift_i     (shift_en),
    .sample_i    (sample_en),
    .rx_i        (bus.dirchan),
    .tx_o        (bus.cs_n),
    .rx_data_o   (dir_rx)
  );

  iso_link_shreg #(
    .Width (NUM_BITS),
    .TxRst (1'b0)
  ) u_hw_lane (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .load_i      (load_en),
    .load_data_i (bus.hwcon_par),
    .shift_i     (shift_en),
    .sample_i    (sample_en),
    .rx_i        (bus.hwflag),
    .tx_o        (bus.hwcon),
    .rx_data_o   (hw_rx)
  );

  assign bus.sclk          = sclk_q;
  assign bus.srclk         = srclk_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.status_change = status_change_q;
  assign bus.dirchan_par   = dirchan_par_q;
  assign bus.hwflag_par    = hwflag_par_q;

endmodule
